// File: rtl/arm_fetch_stage.sv
// Instruction-fetch front end: PC, async-read imem interface and a circular prefetch queue.
// Optional fetch/flush statistics are compiled in with `define ARM_FETCH_STATS_EN.
module arm_fetch_stage #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  Clk,
    input  logic                  Reset,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic                  imem_req,
    input  logic [31:0]           imem_data,
    input  logic                  br_taken,
    input  logic [ADDR_WIDTH-1:0] br_target,
    input  logic                  id_ready,
    output logic                  out_valid,
    output logic [31:0]           out_instr,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [15:0]           stat_fetched,
    output logic [15:0]           stat_flushed
);
    localparam int            PW   = $clog2(DEPTH);
    localparam logic [PW:0]   FULL = (PW+1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] q_pc    [DEPTH];
    logic [31:0]           q_instr [DEPTH];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [PW:0]           count;
    logic                  pop;
    logic                  push;

    // Handshake: an entry leaves the queue on every edge where out_valid and id_ready
    // are both high; out_* hold their value while out_valid=1 and id_ready=0.
    assign out_valid = (count != '0);
    assign pop       = out_valid && id_ready;
    assign imem_req  = !Reset && !br_taken && ((count < FULL) || pop);
    assign push      = imem_req;
    assign imem_addr = fetch_pc;
    assign out_instr = out_valid ? q_instr[rd_ptr] : 32'd0;
    assign out_pc    = out_valid ? q_pc[rd_ptr] : '0;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_pc[i]    <= '0;
                q_instr[i] <= '0;
            end
        end else if (br_taken) begin
            // Redirect wins over push/pop: drop everything and restart at the aligned target.
            fetch_pc <= {br_target[ADDR_WIDTH-1:2], 2'b00};
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                q_pc[wr_ptr]    <= fetch_pc;
                q_instr[wr_ptr] <= imem_data;
                wr_ptr          <= wr_ptr + PW'(1);
                fetch_pc        <= fetch_pc + ADDR_WIDTH'(4);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef ARM_FETCH_STATS_EN
    logic [15:0] fetched_q;
    logic [15:0] flushed_q;
    logic [16:0] flush_sum;

    assign flush_sum    = {1'b0, flushed_q} + 17'(count);
    assign stat_fetched = fetched_q;
    assign stat_flushed = flushed_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            fetched_q <= '0;
            flushed_q <= '0;
        end else if (br_taken) begin
            flushed_q <= flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
        end else if (push && (fetched_q != 16'hFFFF)) begin
            fetched_q <= fetched_q + 16'd1;
        end
    end
`else
    assign stat_fetched = 16'd0;
    assign stat_flushed = 16'd0;
`endif

endmodule

// File: tb/tb_arm_fetch_stage.sv
// Randomized bench for arm_fetch_stage against a queue-based behavioural model.
// Directed test-plan sequences run first, then random reset/redirect/stall traffic.
module tb_arm_fetch_stage;
    localparam int DEPTH = 4;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_data;
    logic        br_taken;
    logic [31:0] br_target;
    logic        id_ready;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [15:0] stat_fetched;
    logic [15:0] stat_flushed;

    arm_fetch_stage #(.ADDR_WIDTH(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .Clk(Clk), .Reset(Reset),
        .imem_addr(imem_addr), .imem_req(imem_req), .imem_data(imem_data),
        .br_taken(br_taken), .br_target(br_target), .id_ready(id_ready),
        .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
        .stat_fetched(stat_fetched), .stat_flushed(stat_flushed)
    );

    // clock / reset block
    always #5 Clk = ~Clk;

    // Instruction memory contents: a fixed, address-dependent pattern.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
    endfunction
    assign imem_data = mem_word(imem_addr);

    // reference model: queue of {pc, instr} plus PC and statistics
    logic [63:0] exp_q[$];
    logic [31:0] m_pc;
    int          m_fetched;
    int          m_flushed;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_state();
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        e_pc    = (exp_q.size() > 0) ? exp_q[0][63:32] : 32'd0;
        e_instr = (exp_q.size() > 0) ? exp_q[0][31:0]  : 32'd0;
        check("imem_addr", imem_addr, m_pc);
        check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
        check("out_pc", out_pc, e_pc);
        check("out_instr", out_instr, e_instr);
`ifdef ARM_FETCH_STATS_EN
        check("stat_fetched", 32'(stat_fetched), 32'(m_fetched));
        check("stat_flushed", 32'(stat_flushed), 32'(m_flushed));
`else
        check("stat_fetched", 32'(stat_fetched), 32'd0);
        check("stat_flushed", 32'(stat_flushed), 32'd0);
`endif
    endtask

    // driver task: apply one cycle of inputs, check the request, advance model and DUT
    task automatic step(input logic rst, input logic br, input logic [31:0] tgt, input logic rdy);
        bit pop;
        bit req;
        Reset     = rst;
        br_taken  = br;
        br_target = tgt;
        id_ready  = rdy;
        #1;
        pop = (exp_q.size() > 0) && rdy;
        req = !rst && !br && ((exp_q.size() < DEPTH) || pop);
        check("imem_req", 32'(imem_req), 32'(req));
        if (rst) begin
            m_pc = 32'h0;
            exp_q.delete();
            m_fetched = 0;
            m_flushed = 0;
        end else if (br) begin
            m_flushed = (m_flushed + exp_q.size() > 65535) ? 65535 : m_flushed + exp_q.size();
            exp_q.delete();
            m_pc = tgt & 32'hFFFF_FFFC;
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (req) begin
                exp_q.push_back({m_pc, mem_word(m_pc)});
                if (m_fetched < 65535) m_fetched++;
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge Clk);
        @(negedge Clk);
        check_state();
    endtask

    initial begin
        Reset = 1'b1; br_taken = 1'b0; br_target = '0; id_ready = 1'b1;
        m_pc = 0; m_fetched = 0; m_flushed = 0;
        @(posedge Clk);
        @(negedge Clk);

        // reset release with streaming decode
        repeat (2) step(1'b1, 1'b0, 32'h0, 1'b1);
        repeat (8) step(1'b0, 1'b0, 32'h0, 1'b1);
        check("stream_pc_direct", out_pc, imem_addr - 32'd4);

        // stall fill, full with pop, redirect while full
        step(1'b1, 1'b0, 32'h0, 1'b0);
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b0);
        check("fill_fetch_pc", imem_addr, 32'd16);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("full_pop_pc", imem_addr, 32'd20);
        step(1'b0, 1'b1, 32'h103, 1'b0);
        check("redir_addr", imem_addr, 32'h100);
        check("redir_valid", 32'(out_valid), 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        check("redir_head", out_pc, 32'h100);
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1);

        // stall release drains in order with no gaps
        step(1'b1, 1'b0, 32'h0, 1'b0);
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b0);
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);

        // reset and redirect on the same edge
        step(1'b1, 1'b1, 32'h200, 1'b1);
        check("rst_br_pc", imem_addr, 32'h0);

        // PC wrap
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("wrap_pc0", out_pc, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("wrap_pc1", out_pc, 32'h0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic        r;
            logic        b;
            logic [31:0] t;
            logic        y;
            r = ($urandom_range(0, 63) == 0);
            b = ($urandom_range(0, 9) == 0);
            t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                             : $urandom;
            y = ($urandom_range(0, 99) < 60);
            step(r, b, t, y);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
